alsu_result_stage: RTL and testbench

ALSU_RESULT_STAGE -- requirements
Module: alsu_result_stage

---
 rtl/alsu_result_pkg.sv | 30 +++
 rtl/alsu_result_fifo.sv | 49 ++++
 rtl/alsu_result_stage.sv | 80 ++++++++
 tb/tb_alsu_result_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alsu_result_pkg.sv
// Shared types and constants for the ALSU result stage.
// Holds the opcode space and the per-entry tag record.
package alsu_result_pkg;

    localparam int OP_W        = 6;
    localparam int NUM_OPS_DEF = 40;
    localparam int CNT_W       = 8;

    // Entry = {result, tag}; the result width is set per instance.
    typedef struct packed {
        logic            carry;
        logic            zero;
        logic [OP_W-1:0] opcode;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic tag_t make_tag(
        input logic            carry,
        input logic            zero,
        input logic [OP_W-1:0] opcode
    );
        tag_t t;
        t.carry  = carry;
        t.zero   = zero;
        t.opcode = opcode;
        return t;
    endfunction

endpackage

// File: rtl/alsu_result_fifo.sv
// Entry storage for the result stage: pointers, occupancy, entry array.
// Depth is a power of two, so pointers wrap by plain overflow.
module alsu_result_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH == 4) ? 2 : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; validity is carried by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/alsu_result_stage.sv
// ALSU result stage: flags, opcode check and result counting
// in front of a small FIFO with a valid/ready handshake on both sides.
module alsu_result_stage
    import alsu_result_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 2,
    parameter int NUM_OPS = NUM_OPS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] result,
    input  logic              carry_in,
    input  logic [OP_W-1:0]   op_code,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic [OP_W-1:0]   op_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              op_err,
    output logic [CNT_W-1:0]  result_cnt
);

    localparam int W = DATA_W + TAG_W;

    logic         accept;
    logic         legal;
    logic         store;
    logic         pop;
    logic         empty;
    logic         full;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    tag_t         head_tag;

    assign legal  = (int'(op_code) < NUM_OPS);
    assign in_ready = !full || out_ready;
    assign accept = in_valid && in_ready;
    assign store  = accept && legal;
    assign pop    = out_valid && out_ready;
    assign wdata  = {result,
                     make_tag(carry_in, (result == '0), op_code)};

    alsu_result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (store),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .empty (empty),
        .full  (full)
    );

    // Head fields are gated so an empty buffer shows all zeros.
    assign out_valid  = !empty;
    assign head_tag   = out_valid ? tag_t'(rdata[TAG_W-1:0]) : '0;
    assign out        = out_valid ? rdata[W-1:TAG_W] : '0;
    assign carry_flag = head_tag.carry;
    assign zero_flag  = head_tag.zero;
    assign op_tag     = head_tag.opcode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_err     <= 1'b0;
            result_cnt <= '0;
        end else begin
            if (accept && !legal) op_err <= 1'b1;
            if (store && result_cnt != '1)
                result_cnt <= result_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alsu_result_stage.sv
// Directed bench for alsu_result_stage: vector table plus
// sequences for back-pressure, illegal opcodes, reset and saturation.
module tb_alsu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] result = '0;
    logic       carry_in = 1'b0;
    logic [5:0] op_code = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out;
    logic       carry_flag;
    logic       zero_flag;
    logic [5:0] op_tag;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       op_err;
    logic [7:0] result_cnt;

    int checks = 0;
    int errors = 0;

    alsu_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .result     (result),
        .carry_in   (carry_in),
        .op_code    (op_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .op_tag     (op_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_err     (op_err),
        .result_cnt (result_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] res;
        logic       c;
        logic [5:0] op;
        logic       ev;
        logic [3:0] eo;
        logic       ec;
        logic       ez;
        logic [5:0] et;
        int         ecnt;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic c,
                         input logic [5:0] op);
        result   = r;
        carry_in = c;
        op_code  = op;
        in_valid = 1'b1;
    endtask

    initial begin
        tbl[0] = '{4'hF, 1'b1, 6'd5,  1'b1, 4'hF, 1'b1, 1'b0, 6'd5,  1};
        tbl[1] = '{4'h0, 1'b1, 6'd7,  1'b1, 4'h0, 1'b1, 1'b1, 6'd7,  2};
        tbl[2] = '{4'hA, 1'b0, 6'd39, 1'b1, 4'hA, 1'b0, 1'b0, 6'd39, 3};
        tbl[3] = '{4'h3, 1'b0, 6'd0,  1'b1, 4'h3, 1'b0, 1'b0, 6'd0,  4};
        tbl[4] = '{4'h9, 1'b1, 6'd40, 1'b0, 4'h0, 1'b0, 1'b0, 6'd0,  4};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_cnt", result_cnt, 0);
        chk("rst_op_err", op_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Single entries: push, check head one cycle later, pop.
        foreach (tbl[i]) begin
            out_ready = 1'b0;
            drive(tbl[i].res, tbl[i].c, tbl[i].op);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("v%0d_out", i), out, tbl[i].eo);
            chk($sformatf("v%0d_carry", i), carry_flag, tbl[i].ec);
            chk($sformatf("v%0d_zero", i), zero_flag, tbl[i].ez);
            chk($sformatf("v%0d_tag", i), op_tag, tbl[i].et);
            chk($sformatf("v%0d_cnt", i), result_cnt, tbl[i].ecnt);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("v%0d_drained", i), out_valid, 0);
        end
        chk("err_after_op40", op_err, 1);

        // Back-pressure: fill, hold third, then push and pop together.
        drive(4'd1, 1'b0, 6'd1);
        step();
        chk("bp_ready1", in_ready, 1);
        drive(4'd2, 1'b0, 6'd1);
        step();
        chk("bp_ready_full", in_ready, 0);
        drive(4'd3, 1'b0, 6'd1);
        step();
        chk("bp_held_head", out, 1);
        chk("bp_held_cnt", result_cnt, 6);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_pop", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_head2", out, 2);
        out_ready = 1'b0;
        #1;
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("bp_head3", out, 3);
        step();
        chk("bp_empty", out_valid, 0);
        chk("bp_cnt", result_cnt, 7);
        out_ready = 1'b0;

        // Illegal opcode: nothing stored, counter holds, flag sticks.
        drive(4'd6, 1'b0, 6'd45);
        step();
        in_valid = 1'b0;
        chk("ill_err", op_err, 1);
        chk("ill_valid", out_valid, 0);
        chk("ill_cnt", result_cnt, 7);
        drive(4'd5, 1'b0, 6'd2);
        step();
        in_valid = 1'b0;
        chk("ill_err_sticky", op_err, 1);
        chk("ill_legal_cnt", result_cnt, 8);
        chk("ill_legal_out", out, 5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Asynchronous reset with a full buffer.
        drive(4'd7, 1'b0, 6'd3);
        step();
        step();
        in_valid = 1'b0;
        chk("ar_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_cnt", result_cnt, 0);
        chk("ar_err", op_err, 0);
        chk("ar_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ar_no_survivor", out_valid, 0);
        chk("ar_ready", in_ready, 1);

        // Counter saturation with streaming push/pop.
        out_ready = 1'b1;
        for (int k = 0; k < 260; k++) begin
            drive(4'(k), 1'b0, 6'd1);
            step();
            if (k == 253) chk("sat_254", result_cnt, 254);
            if (k == 254) chk("sat_255", result_cnt, 255);
        end
        in_valid = 1'b0;
        chk("sat_hold", result_cnt, 255);
        chk("sat_last_out", out, 4'(259));
        step();
        chk("sat_drained", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
